// File: rtl/isa_pkg.sv
// +----------------------------------------------------------------------+
// | isa_pkg -- shared ISA constants, PC-select codes and fetch FSM codes |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package isa_pkg;

   localparam logic [31:0] NOP      = 32'h0000_0000;
   localparam int          STOP_BIT = 31;

   localparam int          TYPE_HI  = 30;
   localparam int          TYPE_LO  = 29;

   typedef enum logic [1:0] {
      TYPE_R = 2'b00,
      TYPE_J = 2'b01,
      TYPE_I = 2'b10,
      TYPE_S = 2'b11
   } instr_type_t;

   localparam logic [1:0] PC_SRC_SEQ = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;
   localparam logic [1:0] PC_SRC_REG = 2'b11;

   localparam logic [1:0] FETCH_RUN  = 2'd0;
   localparam logic [1:0] FETCH_WAIT = 2'd1;
   localparam logic [1:0] FETCH_HALT = 2'd2;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_cycle_if.sv
// +----------------------------------------------------------------------+
// | fetch_cycle_if -- instruction-memory request/response bus            |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface fetch_cycle_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface

`default_nettype wire

// File: rtl/if_id_register.sv
// +----------------------------------------------------------------------+
// | if_id_register -- IF/ID pipeline register with load/hold/bubble      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module if_id_register
   import isa_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        load,
   input  wire logic        hold,
   input  wire logic        bubble,
   input  wire logic [31:0] instr_in,
   input  wire logic [31:0] pc_in,
   output logic [31:0]      Instruction,
   output logic [31:0]      PC_Reg,
   output logic [31:0]      PC_Next,
   output logic             if_valid
);

   // A bubble leaves PC_Reg/PC_Next untouched so decode still sees the last address.
   always_ff @(posedge clk) begin
      if (rst) begin
         Instruction <= NOP;
         PC_Reg      <= 32'h0;
         PC_Next     <= 32'h0;
         if_valid    <= 1'b0;
      end else if (bubble) begin
         Instruction <= NOP;
         if_valid    <= 1'b0;
      end else if (hold) begin
         Instruction <= Instruction;
         if_valid    <= if_valid;
      end else if (load) begin
         Instruction <= instr_in;
         PC_Reg      <= pc_in;
         PC_Next     <= pc_in + 32'd4;
         if_valid    <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_cycle.sv
// +----------------------------------------------------------------------+
// | fetch_cycle -- PC, next-PC select, fetch FSM and IF/ID register      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_cycle
   import isa_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        stall,
   input  wire logic [1:0]  pcSrc,
   input  wire logic [31:0] branch_target,
   input  wire logic [31:0] jump_target,
   input  wire logic [31:0] reg_target,
   fetch_cycle_if.master    imem,
   output logic [31:0]      Instruction,
   output logic [31:0]      PC_Reg,
   output logic [31:0]      PC_Next,
   output logic             if_valid,
   output logic             halted
);

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] target;
   logic        redirect;
   logic        accept;
   logic        bubble;
   logic        hold;

   always_comb begin
      target = branch_target;
      case (pcSrc)
         PC_SRC_BR:  target = branch_target;
         PC_SRC_JMP: target = jump_target;
         PC_SRC_REG: target = reg_target;
         default:    target = branch_target;
      endcase
   end

   assign redirect = (pcSrc != PC_SRC_SEQ);
   assign accept   = !redirect && !stall && (state != FETCH_HALT) && imem.imem_ready;
   // Redirect beats stall; otherwise every unstalled non-accepting cycle is a bubble.
   assign bubble   = redirect || (!stall && !accept);
   assign hold     = stall && !redirect;

   assign imem.imem_req  = (state != FETCH_HALT) && !stall;
   assign imem.imem_addr = pc;
   assign halted         = (state == FETCH_HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         state <= FETCH_RUN;
      end else if (redirect) begin
         pc    <= align_word(target);
         state <= FETCH_RUN;
      end else if (stall || state == FETCH_HALT) begin
         pc    <= pc;
         state <= state;
      end else if (imem.imem_ready) begin
         pc    <= pc + 32'd4;
         state <= imem.imem_rdata[STOP_BIT] ? FETCH_HALT : FETCH_RUN;
      end else begin
         state <= FETCH_WAIT;
      end
   end

   if_id_register u_if_id (
      .clk         (clk),
      .rst         (rst),
      .load        (accept),
      .hold        (hold),
      .bubble      (bubble),
      .instr_in    (imem.imem_rdata),
      .pc_in       (pc),
      .Instruction (Instruction),
      .PC_Reg      (PC_Reg),
      .PC_Next     (PC_Next),
      .if_valid    (if_valid)
   );

endmodule

`default_nettype wire

// File: tb/tb_fetch_cycle.sv
// +----------------------------------------------------------------------+
// | tb_fetch_cycle -- directed self-checking bench for fetch_cycle       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_cycle;
   import isa_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic [1:0]  pcSrc = 2'b00;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] jump_target = 32'h0;
   logic [31:0] reg_target = 32'h0;
   logic        mem_ready = 1'b1;
   logic        stop_en = 1'b0;
   logic [31:0] Instruction, PC_Reg, PC_Next;
   logic        if_valid, halted;
   int          total = 0;
   int          bad = 0;

   fetch_cycle_if bus ();

   // Memory word = low address bits with bit 31 clear; optional stop word at 0x40.
   assign bus.imem_ready = mem_ready;
   always_comb begin
      bus.imem_rdata = {4'h0, bus.imem_addr[27:0]};
      if (stop_en && bus.imem_addr == 32'h40) bus.imem_rdata = 32'h8000_0000;
   end

   fetch_cycle #(.RESET_PC(32'h100)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .pcSrc         (pcSrc),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .reg_target    (reg_target),
      .imem          (bus.master),
      .Instruction   (Instruction),
      .PC_Reg        (PC_Reg),
      .PC_Next       (PC_Next),
      .if_valid      (if_valid),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      logic [97:0] exp_v;
      tick();
      tick();
      exp_v = {32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
      total++;
      if ({Instruction, PC_Reg, PC_Next, if_valid, halted} !== exp_v) begin
         bad++;
         $display("FAIL reset_ifid got %h exp %h", {Instruction, PC_Reg, PC_Next, if_valid, halted}, exp_v);
      end
      rst = 1'b0;
      #1;
      total++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) begin
         bad++;
         $display("FAIL reset_req got %b/%h exp 1/00000100", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_sequential();
      tick();
      total++;
      if ({bus.imem_addr, Instruction, PC_Reg, PC_Next, if_valid} !== {32'h104, 32'h100, 32'h100, 32'h104, 1'b1}) begin
         bad++;
         $display("FAIL seq1 got addr=%h ins=%h pcr=%h pcn=%h v=%b", bus.imem_addr, Instruction, PC_Reg, PC_Next, if_valid);
      end
      tick();
      total++;
      if ({bus.imem_addr, PC_Reg, PC_Next, if_valid} !== {32'h108, 32'h104, 32'h108, 1'b1}) begin
         bad++;
         $display("FAIL seq2 got addr=%h pcr=%h pcn=%h v=%b", bus.imem_addr, PC_Reg, PC_Next, if_valid);
      end
   endtask

   task automatic test_wait();
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b0;
         tick();
         total++;
         if ({dut.state, bus.imem_addr, Instruction, PC_Reg, if_valid} !== {FETCH_WAIT, 32'h108, NOP, 32'h104, 1'b0}) begin
            bad++;
            $display("FAIL wait%0d got st=%0d addr=%h ins=%h pcr=%h v=%b", i, dut.state, bus.imem_addr, Instruction, PC_Reg, if_valid);
         end
      end
      mem_ready = 1'b1;
      tick();
      total++;
      if ({bus.imem_addr, Instruction, PC_Reg, if_valid} !== {32'h10C, 32'h108, 32'h108, 1'b1}) begin
         bad++;
         $display("FAIL wait_resume got addr=%h ins=%h pcr=%h v=%b", bus.imem_addr, Instruction, PC_Reg, if_valid);
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      #1;
      total++;
      if (bus.imem_req !== 1'b0) begin
         bad++;
         $display("FAIL stall_req got %b exp 0", bus.imem_req);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if ({bus.imem_req, bus.imem_addr, Instruction, PC_Reg, if_valid} !== {1'b0, 32'h10C, 32'h108, 32'h108, 1'b1}) begin
            bad++;
            $display("FAIL stall%0d got req=%b addr=%h ins=%h pcr=%h v=%b", i, bus.imem_req, bus.imem_addr, Instruction, PC_Reg, if_valid);
         end
      end
      stall = 1'b0;
      tick();
      total++;
      if ({bus.imem_addr, PC_Reg, if_valid} !== {32'h110, 32'h10C, 1'b1}) begin
         bad++;
         $display("FAIL stall_resume got addr=%h pcr=%h v=%b", bus.imem_addr, PC_Reg, if_valid);
      end
   endtask

   task automatic test_redirect_stall();
      pcSrc = PC_SRC_BR;
      branch_target = 32'h203;
      stall = 1'b1;
      tick();
      pcSrc = PC_SRC_SEQ;
      stall = 1'b0;
      total++;
      if ({bus.imem_addr, Instruction, PC_Reg, if_valid} !== {32'h200, NOP, 32'h10C, 1'b0}) begin
         bad++;
         $display("FAIL redirect_bubble got addr=%h ins=%h pcr=%h v=%b", bus.imem_addr, Instruction, PC_Reg, if_valid);
      end
      tick();
      total++;
      if ({bus.imem_addr, Instruction, PC_Reg, PC_Next, if_valid} !== {32'h204, 32'h200, 32'h200, 32'h204, 1'b1}) begin
         bad++;
         $display("FAIL redirect_target got addr=%h ins=%h pcr=%h pcn=%h v=%b", bus.imem_addr, Instruction, PC_Reg, PC_Next, if_valid);
      end
   endtask

   task automatic test_halt();
      stop_en = 1'b1;
      pcSrc = PC_SRC_JMP;
      jump_target = 32'h40;
      tick();
      pcSrc = PC_SRC_SEQ;
      tick();
      total++;
      if ({Instruction, PC_Reg, PC_Next, if_valid, halted} !== {32'h8000_0000, 32'h40, 32'h44, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL halt_stop got ins=%h pcr=%h pcn=%h v=%b h=%b", Instruction, PC_Reg, PC_Next, if_valid, halted);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if ({bus.imem_req, bus.imem_addr, Instruction, if_valid, halted} !== {1'b0, 32'h44, NOP, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL halt_hold%0d got req=%b addr=%h ins=%h v=%b h=%b", i, bus.imem_req, bus.imem_addr, Instruction, if_valid, halted);
         end
      end
      pcSrc = PC_SRC_JMP;
      jump_target = 32'h80;
      tick();
      pcSrc = PC_SRC_SEQ;
      #1;
      total++;
      if ({bus.imem_req, bus.imem_addr, if_valid, halted} !== {1'b1, 32'h80, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL halt_exit got req=%b addr=%h v=%b h=%b", bus.imem_req, bus.imem_addr, if_valid, halted);
      end
      tick();
      total++;
      if ({PC_Reg, Instruction, if_valid} !== {32'h80, 32'h80, 1'b1}) begin
         bad++;
         $display("FAIL halt_refetch got pcr=%h ins=%h v=%b", PC_Reg, Instruction, if_valid);
      end
   endtask

   task automatic test_wrap();
      pcSrc = PC_SRC_REG;
      reg_target = 32'hFFFF_FFFF;
      tick();
      pcSrc = PC_SRC_SEQ;
      total++;
      if (bus.imem_addr !== 32'hFFFF_FFFC) begin
         bad++;
         $display("FAIL wrap_align got %h exp fffffffc", bus.imem_addr);
      end
      tick();
      total++;
      if ({PC_Reg, PC_Next, bus.imem_addr, if_valid} !== {32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1}) begin
         bad++;
         $display("FAIL wrap got pcr=%h pcn=%h addr=%h v=%b", PC_Reg, PC_Next, bus.imem_addr, if_valid);
      end
   endtask

   task automatic test_reset_mid();
      mem_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_ready = 1'b1;
      #1;
      total++;
      if ({dut.state, bus.imem_req, bus.imem_addr, PC_Reg, if_valid} !== {FETCH_RUN, 1'b1, 32'h100, 32'h0, 1'b0}) begin
         bad++;
         $display("FAIL reset_wait got st=%0d req=%b addr=%h pcr=%h v=%b", dut.state, bus.imem_req, bus.imem_addr, PC_Reg, if_valid);
      end
      pcSrc = PC_SRC_JMP;
      jump_target = 32'h40;
      tick();
      pcSrc = PC_SRC_SEQ;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      total++;
      if ({halted, bus.imem_req, bus.imem_addr, Instruction, if_valid} !== {1'b0, 1'b1, 32'h100, NOP, 1'b0}) begin
         bad++;
         $display("FAIL reset_halt got h=%b req=%b addr=%h ins=%h v=%b", halted, bus.imem_req, bus.imem_addr, Instruction, if_valid);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wait();
      test_stall();
      test_redirect_stall();
      test_halt();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_cycle.md
# fetch_cycle

Instruction-fetch stage of the 5-bit-opcode, 32-bit-instruction pipeline. Owns the program counter, drives the instruction-memory request, selects the next PC from sequential/branch/jump/register targets, and holds the IF/ID pipeline register. It feeds `Instruction`, `PC_Reg` and `PC_Next` directly to the decode stage. It halts fetch on an instruction whose stop bit (bit 31) is set.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk`  in  1: sole clock, all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hazard-unit hold; freezes PC and IF/ID.
- `pcSrc`  in  2: next-PC select.
  - 00: sequential.
  - 01: `branch_target`.
  - 10: `jump_target`.
  - 11: `reg_target`.
- `branch_target`  in  32: taken-branch address.
- `jump_target`  in  32: J-type address (decode computes it from the signed 24-bit immediate).
- `reg_target`  in  32: register-indirect address.
- `imem_req`  out  1: fetch request this cycle.
- `imem_addr`  out  32: fetch address (current PC).
- `imem_ready`  in  1: `imem_rdata` is valid for `imem_addr` in the same cycle.
- `imem_rdata`  in  32: instruction word.
- `Instruction`  out  32: IF/ID instruction.
- `PC_Reg`  out  32: address of `Instruction`.
- `PC_Next`  out  32: `PC_Reg` + 4.
- `if_valid`  out  1: IF/ID holds a real instruction (0 means bubble).
- `halted`  out  1: FSM is in HALT.

## Operation
- FSM states:
  - RUN: fetching.
  - WAIT: last request not accepted.
  - HALT: stop instruction captured.
- `imem_req` = (state != HALT) && !`stall`. `imem_addr` = PC in every state.
- Per-cycle priority, highest first:
  - `rst`:
    - PC ← `RESET_PC`.
    - IF/ID ← {NOP, 0, 0}, `if_valid` ← 0.
    - State ← RUN.
  - `pcSrc` != 00 (redirect):
    - PC ← selected target with bits [1:0] forced to 00.
    - IF/ID ← bubble, state ← RUN.
    - Any memory data returned this cycle is discarded.
    - A redirect while in HALT cancels the halt, because that stop instruction was on a squashed path.
  - `stall`: PC, IF/ID, `if_valid` and state all hold.
  - state == HALT: PC holds, IF/ID ← bubble.
  - `imem_ready` == 1:
    - `Instruction` ← `imem_rdata`, `PC_Reg` ← PC, `PC_Next` ← PC+4, `if_valid` ← 1.
    - PC ← PC+4.
    - State ← HALT if `imem_rdata`[31] == 1, else RUN.
  - Otherwise: PC holds, IF/ID ← bubble, state ← WAIT.
- Bubble means `Instruction` = NOP (32'h0000_0000), `if_valid` = 0. `PC_Reg` and `PC_Next` hold their previous values.
- Arithmetic:
  - All PC arithmetic is 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - No alignment checking. Target low bits are silently cleared.
- The stop instruction itself is delivered to decode with `if_valid` = 1. Nothing after it is fetched until a redirect or reset.

## Timing
- Reset values:
  - PC = `RESET_PC`.
  - `Instruction` = 0, `PC_Reg` = 0, `PC_Next` = 0.
  - `if_valid` = 0, `halted` = 0, state = RUN.
  - `imem_req` = 1 in the first cycle after `rst` deasserts.
- Latency: a word accepted in cycle N appears on the IF/ID outputs in cycle N+1.
- Throughput: one instruction per cycle with a zero-wait memory.
- Redirect in cycle N: `imem_addr` = target in cycle N+1, IF/ID is a bubble in N+1, and the first target instruction appears in IF/ID in N+2.
- Redirect and `stall` in the same cycle: the redirect wins and the bubble is inserted.
- `rst` asserted mid-WAIT or mid-HALT: the next cycle is fully in reset state. No pending request survives.
- `halted` is registered and asserts in the same cycle the stop instruction appears on `Instruction`.

## Structure
- Shared package `isa_pkg` holds:
  - `NOP` = 32'h0.
  - `STOP_BIT` = 31.
  - Type-field bounds [30:29] and `TYPE_R/J/I/S` = 00/01/10/11.
  - `PC_SRC_SEQ/BR/JMP/REG` = 00/01/10/11.
  - `FETCH_RUN/WAIT/HALT` state encoding.
- One sub-module, `if_id_register`, holds the IF/ID register. Controls: load, hold, bubble, reset.
- The PC register, next-PC mux and FSM live in `fetch_cycle`.

## Test plan
- Reset with `RESET_PC` = 32'h100 and zero-wait memory returning words with bit 31 = 0:
  - `imem_addr` steps 100, 104, 108.
  - IF/ID shows `PC_Reg` 100/104 with `PC_Next` 104/108, one per cycle, and `if_valid` = 1 from the second cycle.
- `imem_ready` low for 3 cycles at PC 32'h108:
  - State is WAIT, `imem_addr` holds 108, and three bubbles are produced.
  - When ready rises, `PC_Reg` = 108 and the PC advances to 10C.
- `stall` for 2 cycles with a valid instruction in IF/ID: `Instruction`, `PC_Reg` and `imem_addr` are unchanged and `imem_req` = 0. Fetch resumes sequentially afterwards.
- `pcSrc` = 01 with `branch_target` = 32'h203 while `stall` = 1: the next `imem_addr` is 32'h200, a bubble is inserted, and the target word reaches IF/ID two cycles later.
- Fetch of 32'h8000_0000 at PC 32'h40:
  - It is delivered with `if_valid` = 1 and `halted` = 1, then bubbles follow with `imem_req` = 0.
  - A later `pcSrc` = 10 with `jump_target` 32'h80 resumes fetch at 32'h80 and `halted` drops.
- PC at 32'hFFFF_FFFC with a ready word: `PC_Next` = 0 and the following `imem_addr` = 0.
